// File: rtl/axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_mem_slave
// Description : AXI4 SRAM slave with FIXED/INCR/WRAP bursts, one outstanding
//               write and one outstanding read, independent R and W paths.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = ADDR_WIDTH'(1) << size;
        mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * incr - ADDR_WIDTH'(1);
        case (burst)
            BURST_INCR: next_addr = addr + incr;
            BURST_WRAP: next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default:    next_addr = addr;
        endcase
    endfunction

    function automatic logic cmd_error(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        cmd_error = (size > 3'(ADDR_LSB)) || (burst == 2'b11) ||
                    ((burst == BURST_WRAP) && !((len == 8'd1) || (len == 8'd3) ||
                                                (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic word_oob(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word     = addr >> ADDR_LSB;
        word_oob = (word >= ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    // ---------------------------------------------------------------- write
    wstate_t               w_state, w_next;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len, w_cnt;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  w_cmd_err, w_err;
    logic                  aw_fire, w_fire, b_fire, w_last_beat, w_beat_oob, w_beat_err, w_mem_en;

    assign aw_fire     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire      = S_AXI_WVALID && S_AXI_WREADY;
    assign b_fire      = S_AXI_BVALID && S_AXI_BREADY;
    assign w_last_beat = (w_cnt == aw_len);
    assign w_beat_oob  = word_oob(aw_addr);
    assign w_beat_err  = w_beat_oob || (S_AXI_WLAST != w_last_beat);
    assign w_mem_en    = w_fire && !w_cmd_err && !w_beat_oob;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_next = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_fire) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_id         <= '0;
            aw_addr       <= '0;
            aw_len        <= '0;
            aw_size       <= '0;
            aw_burst      <= '0;
            w_cnt         <= '0;
            w_cmd_err     <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            w_state       <= w_next;
            S_AXI_AWREADY <= (w_next == W_IDLE);
            S_AXI_WREADY  <= (w_next == W_DATA);
            S_AXI_BVALID  <= (w_next == W_RESP);
            if (aw_fire) begin
                aw_id     <= S_AXI_AWID;
                aw_addr   <= S_AXI_AWADDR;
                aw_len    <= S_AXI_AWLEN;
                aw_size   <= S_AXI_AWSIZE;
                aw_burst  <= S_AXI_AWBURST;
                w_cnt     <= '0;
                w_err     <= 1'b0;
                w_cmd_err <= cmd_error(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
            end
            if (w_fire) begin
                aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
                w_cnt   <= w_cnt + 8'd1;
                w_err   <= w_err | w_beat_err;
                if (w_last_beat) begin
                    S_AXI_BID   <= aw_id;
                    S_AXI_BRESP <= (w_err || w_beat_err || w_cmd_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Memory array is deliberately outside the reset domain.
    always_ff @(posedge ACLK) begin
        if (w_mem_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[aw_addr[ADDR_LSB +: IDX_WIDTH]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    rstate_t               r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_load_addr;
    logic [7:0]            ar_len, r_cnt, r_load_cnt, r_load_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  r_cmd_err, r_load_cmd_err, r_load_oob, ar_fire, r_fire, r_load;

    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_fire  = S_AXI_RVALID && S_AXI_RREADY;
    assign r_load  = ar_fire || (r_fire && !S_AXI_RLAST);

    // The beat being loaded comes from the AR channel on a new command and
    // from the latched command for every following beat.
    assign r_load_addr    = (r_state == R_IDLE) ? S_AXI_ARADDR
                                                : next_addr(r_addr, ar_len, ar_size, ar_burst);
    assign r_load_cmd_err = (r_state == R_IDLE) ? cmd_error(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST)
                                                : r_cmd_err;
    assign r_load_len     = (r_state == R_IDLE) ? S_AXI_ARLEN : ar_len;
    assign r_load_cnt     = (r_state == R_IDLE) ? 8'd0 : r_cnt + 8'd1;
    assign r_load_oob     = word_oob(r_load_addr);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_DATA;
            R_DATA:  if (r_fire && S_AXI_RLAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            r_addr        <= '0;
            ar_len        <= '0;
            ar_size       <= '0;
            ar_burst      <= '0;
            r_cnt         <= '0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_IDLE);
            S_AXI_RVALID  <= (r_next == R_DATA);
            if (ar_fire) begin
                S_AXI_RID <= S_AXI_ARID;
                ar_len    <= S_AXI_ARLEN;
                ar_size   <= S_AXI_ARSIZE;
                ar_burst  <= S_AXI_ARBURST;
                r_cmd_err <= r_load_cmd_err;
            end
            if (r_load) begin
                r_addr      <= r_load_addr;
                r_cnt       <= r_load_cnt;
                S_AXI_RLAST <= (r_load_cnt == r_load_len);
                if (r_load_cmd_err || r_load_oob) begin
                    S_AXI_RDATA <= '0;
                    S_AXI_RRESP <= RESP_SLVERR;
                end else begin
                    S_AXI_RDATA <= mem[r_load_addr[ADDR_LSB +: IDX_WIDTH]];
                    S_AXI_RRESP <= RESP_OKAY;
                end
            end else if (r_fire && S_AXI_RLAST) begin
                S_AXI_RLAST <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_burst_mem_slave
// Description : Randomised self-checking bench with a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_mem_slave;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int MEM_DEPTH  = 1024;
    localparam int TIMEOUT    = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [ID_WIDTH-1:0]   S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic [7:0]            S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]            S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]            S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic                  S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic                  S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic                  S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
    logic [DATA_WIDTH-1:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [int];
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id;
    int          rd_beats;

    always #5 clk = ~clk;

    axi4_burst_mem_slave #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH(ID_WIDTH), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    // ------------------------------------------------------------ reference model
    function automatic bit model_cmd_err(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int beat);
        longint incr, bound, base, s;
        incr = longint'(1) << size;
        s    = longint'(start);
        case (burst)
            2'b01: return 32'(s + beat * incr);
            2'b10: begin
                bound = (longint'(len) + 1) * incr;
                base  = s - (s % bound);
                return 32'(base + ((s - base + beat * incr) % bound));
            end
            default: return start;
        endcase
    endfunction

    function automatic bit model_oob(input logic [31:0] addr);
        return (addr / 4) >= MEM_DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int bad_last, output logic [1:0] resp);
        bit cmd, err;
        logic [31:0] a;
        cmd = model_cmd_err(len, size, burst);
        err = cmd || (bad_last >= 0 && bad_last != int'(len));
        for (int i = 0; i <= int'(len); i++) begin
            a = model_addr(addr, len, size, burst, i);
            if (model_oob(a)) err = 1'b1;
            else if (!cmd)
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) ref_mem[int'(a / 4) * 4 + b] = wr_data[i][b*8 +: 8];
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic model_read(input logic [31:0] addr, input bit cmd, output logic [31:0] data,
                              output logic [31:0] mask, output logic [1:0] resp);
        int idx;
        data = '0; mask = '0; resp = 2'b00;
        if (cmd || model_oob(addr)) begin
            mask = '1; resp = 2'b10;
        end else begin
            for (int b = 0; b < 4; b++) begin
                idx = int'(addr / 4) * 4 + b;
                if (ref_mem.exists(idx)) begin
                    data[b*8 +: 8] = ref_mem[idx];
                    mask[b*8 +: 8] = 8'hFF;
                end
            end
        end
    endtask

    // ------------------------------------------------------------ bus drivers
    task automatic drive_idle();
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    endtask

    task automatic timeout_fail(input string what);
        checks++; failures++;
        $display("FAIL timeout_%s waited=%0d cycles required=handshake", what, TIMEOUT);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input int bad_last,
                             output logic [1:0] resp, output logic [3:0] bid);
        int n;
        resp = 2'b11; bid = '0;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        if (n >= TIMEOUT) begin S_AXI_AWVALID = 1'b0; timeout_fail("aw"); return; end
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 3) == 0) begin S_AXI_WVALID = 1'b0; @(posedge clk); #1; end
            S_AXI_WDATA = wr_data[i]; S_AXI_WSTRB = wr_strb[i];
            S_AXI_WLAST = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            S_AXI_WVALID = 1'b1;
            n = 0;
            while (!S_AXI_WREADY && n < TIMEOUT) begin @(posedge clk); #1; n++; end
            if (n >= TIMEOUT) begin S_AXI_WVALID = 1'b0; timeout_fail("w"); return; end
            @(posedge clk); #1;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        if (n >= TIMEOUT) begin timeout_fail("b"); return; end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        resp = S_AXI_BRESP; bid = S_AXI_BID;
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input bit rand_ready);
        int n;
        bit done;
        rd_beats = 0; rd_id = '0;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        if (n >= TIMEOUT) begin S_AXI_ARVALID = 1'b0; timeout_fail("ar"); return; end
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < TIMEOUT * 4) begin
            S_AXI_RREADY = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rd_beats == 0) rd_id = S_AXI_RID;
                if (rd_beats < 256) begin
                    rd_data[rd_beats] = S_AXI_RDATA;
                    rd_resp[rd_beats] = S_AXI_RRESP;
                    rd_last[rd_beats] = S_AXI_RLAST;
                end
                rd_beats++;
                done = S_AXI_RLAST;
            end
            @(posedge clk); #1; n++;
        end
        S_AXI_RREADY = 1'b0;
        if (!done) timeout_fail("rlast");
    endtask

    // Compares the collected read burst against the model, beat by beat.
    task automatic verify_read(input string name, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
        logic [31:0] exp_d, mask, a;
        logic [1:0]  exp_r;
        bit cmd;
        cmd = model_cmd_err(len, size, burst);
        checks++;
        if (rd_beats !== int'(len) + 1 || rd_id !== id) begin
            failures++;
            $display("FAIL %s_beats got=%0d id=%0h exp=%0d id=%0h", name, rd_beats, rd_id, int'(len) + 1, id);
        end
        for (int i = 0; i <= int'(len) && i < rd_beats; i++) begin
            a = model_addr(addr, len, size, burst, i);
            model_read(a, cmd, exp_d, mask, exp_r);
            checks++;
            if ((rd_data[i] & mask) !== (exp_d & mask) || rd_resp[i] !== exp_r ||
                rd_last[i] !== (i == int'(len))) begin
                failures++;
                $display("FAIL %s_beat%0d addr=%08h got data=%08h resp=%0b last=%0b exp data=%08h/%08h resp=%0b last=%0b",
                         name, i, a, rd_data[i], rd_resp[i], rd_last[i], exp_d, mask, exp_r, i == int'(len));
            end
        end
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        drive_idle();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST} !== 6'b0) begin
            failures++;
            $display("FAIL reset_handshakes got=%06b exp=000000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST});
        end
        checks++;
        if (S_AXI_BID !== '0 || S_AXI_BRESP !== '0 || S_AXI_RID !== '0 || S_AXI_RDATA !== '0 || S_AXI_RRESP !== '0) begin
            failures++;
            $display("FAIL reset_payload got bid=%0h bresp=%0b rid=%0h rdata=%08h rresp=%0b exp=all zero",
                     S_AXI_BID, S_AXI_BRESP, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (S_AXI_AWREADY !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got aw=%0b ar=%0b exp=0 0", S_AXI_AWREADY, S_AXI_ARREADY);
        end
        @(posedge clk); #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11000) begin
            failures++;
            $display("FAIL ready_after_release got=%05b exp=11000",
                     {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp, exp_resp;
        logic [3:0] bid;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + i; wr_strb[i] = 4'hF; end
        axi_write(32'h100, 8'd3, 3'd2, 2'b01, 4'h5, -1, resp, bid);
        model_write(32'h100, 8'd3, 3'd2, 2'b01, -1, exp_resp);
        checks++;
        if (resp !== 2'b00 || bid !== 4'h5) begin
            failures++;
            $display("FAIL incr_bresp got resp=%0b id=%0h exp resp=00 id=5", resp, bid);
        end
        axi_read(32'h100, 8'd3, 3'd2, 2'b01, 4'h9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 + i || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL incr_read%0d got=%08h resp=%0b last=%0b exp=%08h resp=00 last=%0b",
                         i, rd_data[i], rd_resp[i], rd_last[i], 32'hA0 + i, i == 3);
            end
        end
        checks++;
        if (rd_beats !== 4 || rd_id !== 4'h9) begin
            failures++;
            $display("FAIL incr_read_count got beats=%0d id=%0h exp beats=4 id=9", rd_beats, rd_id);
        end
    endtask

    task automatic test_wrap_fixed();
        logic [1:0]  resp, exp_resp;
        logic [3:0]  bid;
        logic [31:0] exp_wrap [4];
        exp_wrap = '{32'h38, 32'h3C, 32'h30, 32'h34};
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h30 + 4 * i; wr_strb[i] = 4'hF; end
        axi_write(32'h30, 8'd3, 3'd2, 2'b01, 4'h1, -1, resp, bid);
        model_write(32'h30, 8'd3, 3'd2, 2'b01, -1, exp_resp);
        axi_read(32'h38, 8'd3, 3'd2, 2'b10, 4'h2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp_wrap[i] || rd_resp[i] !== 2'b00) begin
                failures++;
                $display("FAIL wrap_beat%0d got=%08h resp=%0b exp=%08h resp=00", i, rd_data[i], rd_resp[i], exp_wrap[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin wr_data[i] = 32'h1 + i; wr_strb[i] = 4'hF; end
        axi_write(32'h40, 8'd2, 3'd2, 2'b00, 4'h3, -1, resp, bid);
        model_write(32'h40, 8'd2, 3'd2, 2'b00, -1, exp_resp);
        axi_read(32'h40, 8'd0, 3'd2, 2'b01, 4'h3, 1'b0);
        checks++;
        if (rd_data[0] !== 32'h3 || resp !== 2'b00) begin
            failures++;
            $display("FAIL fixed_write got mem=%08h bresp=%0b exp mem=00000003 bresp=00", rd_data[0], resp);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp, exp_resp;
        logic [3:0] bid;
        wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
        axi_write(32'h80, 8'd0, 3'd2, 2'b01, 4'h0, -1, resp, bid);
        model_write(32'h80, 8'd0, 3'd2, 2'b01, -1, exp_resp);
        wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'b0101;
        axi_write(32'h80, 8'd0, 3'd2, 2'b01, 4'h0, -1, resp, bid);
        model_write(32'h80, 8'd0, 3'd2, 2'b01, -1, exp_resp);
        axi_read(32'h80, 8'd0, 3'd2, 2'b01, 4'h0, 1'b0);
        checks++;
        if (rd_data[0] !== 32'hFF22_FF44) begin
            failures++;
            $display("FAIL strobe_merge got=%08h exp=ff22ff44", rd_data[0]);
        end
    endtask

    task automatic test_rready_stall();
        int pat [4];
        int beats, cyc, n;
        bit prev_stall, prev_last;
        logic [31:0] prev_data;
        pat = '{1, 0, 0, 1};
        S_AXI_ARID = 4'h7; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd3;
        S_AXI_ARSIZE = 3'd2; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        beats = 0; cyc = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        while (beats < 4 && cyc < 100) begin
            S_AXI_RREADY = (pat[cyc % 4] != 0);
            if (prev_stall) begin
                checks++;
                if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== prev_data || S_AXI_RLAST !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got valid=%0b data=%08h last=%0b exp valid=1 data=%08h last=%0b",
                             cyc, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, prev_data, prev_last);
                end
            end
            prev_stall = S_AXI_RVALID && !S_AXI_RREADY;
            prev_data = S_AXI_RDATA; prev_last = S_AXI_RLAST;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                checks++;
                if (S_AXI_RDATA !== 32'hA0 + beats || S_AXI_RLAST !== (beats == 3)) begin
                    failures++;
                    $display("FAIL stall_beat%0d got=%08h last=%0b exp=%08h last=%0b",
                             beats, S_AXI_RDATA, S_AXI_RLAST, 32'hA0 + beats, beats == 3);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        S_AXI_RREADY = 1'b0;
        checks++;
        if (beats !== 4 || S_AXI_RVALID !== 1'b0) begin
            failures++;
            $display("FAIL stall_count got beats=%0d rvalid_after=%0b exp beats=4 rvalid_after=0", beats, S_AXI_RVALID);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp, exp_resp;
        logic [3:0] bid;
        wr_data[0] = 32'hCAFE_F00D; wr_strb[0] = 4'hF;
        axi_write(32'h0, 8'd0, 3'd2, 2'b01, 4'h0, -1, resp, bid);
        model_write(32'h0, 8'd0, 3'd2, 2'b01, -1, exp_resp);
        wr_data[0] = 32'hDEAD_BEEF;
        axi_write(MEM_DEPTH * 4, 8'd0, 3'd2, 2'b01, 4'hA, -1, resp, bid);
        model_write(MEM_DEPTH * 4, 8'd0, 3'd2, 2'b01, -1, exp_resp);
        checks++;
        if (resp !== 2'b10 || exp_resp !== 2'b10) begin
            failures++;
            $display("FAIL oob_bresp got=%0b model=%0b exp=10", resp, exp_resp);
        end
        axi_read(32'h0, 8'd0, 3'd2, 2'b01, 4'h0, 1'b0);
        verify_read("oob_no_alias", 32'h0, 8'd0, 3'd2, 2'b01, 4'h0);
        wr_data[0] = 32'h1234_5678; wr_data[1] = 32'h9ABC_DEF0; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        axi_write(32'hFFC, 8'd0, 3'd2, 2'b01, 4'h0, -1, resp, bid);
        model_write(32'hFFC, 8'd0, 3'd2, 2'b01, -1, exp_resp);
        axi_read(32'hFFC, 8'd1, 3'd2, 2'b01, 4'hB, 1'b1);
        verify_read("end_cross", 32'hFFC, 8'd1, 3'd2, 2'b01, 4'hB);
        wr_data[0] = 32'h0BAD_BAD0;
        axi_write(32'h0, 8'd0, 3'd2, 2'b11, 4'h4, -1, resp, bid);
        model_write(32'h0, 8'd0, 3'd2, 2'b11, -1, exp_resp);
        checks++;
        if (resp !== 2'b10) begin
            failures++;
            $display("FAIL burst11_bresp got=%0b exp=10", resp);
        end
        axi_read(32'h0, 8'd0, 3'd2, 2'b01, 4'h0, 1'b0);
        verify_read("burst11_no_write", 32'h0, 8'd0, 3'd2, 2'b01, 4'h0);
        for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        axi_write(32'h900, 8'd3, 3'd2, 2'b01, 4'h6, 1, resp, bid);
        model_write(32'h900, 8'd3, 3'd2, 2'b01, 1, exp_resp);
        checks++;
        if (resp !== 2'b10 || bid !== 4'h6) begin
            failures++;
            $display("FAIL wlast_early got resp=%0b id=%0h exp resp=10 id=6", resp, bid);
        end
        axi_read(32'h100, 8'd2, 3'd2, 2'b10, 4'hC, 1'b1);
        verify_read("wrap_len2", 32'h100, 8'd2, 3'd2, 2'b10, 4'hC);
        axi_read(32'h100, 8'd1, 3'd3, 2'b01, 4'hD, 1'b0);
        verify_read("size_too_big", 32'h100, 8'd1, 3'd3, 2'b01, 4'hD);
    endtask

    task automatic test_random();
        logic [1:0]  resp, exp_resp, burst;
        logic [3:0]  bid, id;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
        int lens [4];
        lens = '{1, 3, 7, 15};
        for (int t = 0; t < 16; t++) begin
            burst = 2'($urandom_range(0, 2));
            size  = 3'($urandom_range(0, 2));
            len   = (burst == 2'b10) ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 15));
            addr  = (32'h400 + 32'($urandom_range(0, 32'h300))) & ~((32'd1 << size) - 1);
            id    = 4'($urandom);
            for (int i = 0; i <= int'(len); i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
            axi_write(addr, len, size, burst, id, -1, resp, bid);
            model_write(addr, len, size, burst, -1, exp_resp);
            checks++;
            if (resp !== exp_resp || bid !== id) begin
                failures++;
                $display("FAIL rand%0d_bresp got resp=%0b id=%0h exp resp=%0b id=%0h", t, resp, bid, exp_resp, id);
            end
            axi_read(addr, len, size, burst, ~id, 1'b1);
            verify_read("rand", addr, len, size, burst, ~id);
        end
    endtask

    task automatic test_concurrent_and_reset();
        logic [1:0] resp, exp_resp;
        logic [3:0] bid;
        for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        axi_write(32'h200, 8'd15, 3'd2, 2'b01, 4'h1, -1, resp, bid);
        model_write(32'h200, 8'd15, 3'd2, 2'b01, -1, exp_resp);
        for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        fork
            axi_write(32'h300, 8'd15, 3'd2, 2'b01, 4'h2, -1, resp, bid);
            axi_read(32'h200, 8'd15, 3'd2, 2'b01, 4'h3, 1'b1);
        join
        model_write(32'h300, 8'd15, 3'd2, 2'b01, -1, exp_resp);
        verify_read("concurrent_read", 32'h200, 8'd15, 3'd2, 2'b01, 4'h3);
        checks++;
        if (resp !== 2'b00 || bid !== 4'h2) begin
            failures++;
            $display("FAIL concurrent_bresp got resp=%0b id=%0h exp resp=00 id=2", resp, bid);
        end
        // Abandon a write and a read mid-burst.
        S_AXI_AWADDR = 32'h800; S_AXI_AWLEN = 8'd15; S_AXI_AWSIZE = 3'd2; S_AXI_AWBURST = 2'b01;
        S_AXI_ARADDR = 32'h200; S_AXI_ARLEN = 8'd15; S_AXI_ARSIZE = 3'd2; S_AXI_ARBURST = 2'b01;
        S_AXI_AWVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_WDATA = 32'h5555_AAAA; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
        S_AXI_RREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (S_AXI_WREADY !== 1'b1 || S_AXI_RVALID !== 1'b1) begin
            failures++;
            $display("FAIL midburst_active got wready=%0b rvalid=%0b exp=1 1", S_AXI_WREADY, S_AXI_RVALID);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST} !== 6'b0) begin
            failures++;
            $display("FAIL midburst_reset got=%06b exp=000000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST});
        end
        drive_idle();
        for (int a = 32'h800; a < 32'h840; a++) if (ref_mem.exists(a)) ref_mem.delete(a);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11000) begin
            failures++;
            $display("FAIL post_reset_ready got=%05b exp=11000",
                     {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        axi_read(32'h300, 8'd15, 3'd2, 2'b01, 4'h4, 1'b1);
        verify_read("retained_300", 32'h300, 8'd15, 3'd2, 2'b01, 4'h4);
        axi_read(32'h100, 8'd3, 3'd2, 2'b01, 4'h5, 1'b0);
        verify_read("retained_100", 32'h100, 8'd3, 3'd2, 2'b01, 4'h5);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_strobe();
        test_rready_stall();
        test_errors();
        test_random();
        test_concurrent_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
